// File: rtl/mux16_rr_arbiter_if.sv
// Bus bundle between the 16-way round-robin arbiter and its requesters.
//   req/done/din : driven by the requester side (master)
//   sel/gnt/gnt_valid/timeout/dout : driven by the arbiter (slave)
interface mux16_rr_arbiter_if;
  logic [15:0] req;
  logic        done;
  logic [15:0] din;
  logic [3:0]  sel;
  logic [15:0] gnt;
  logic        gnt_valid;
  logic        timeout;
  logic        dout;

  modport master (
    output req, done, din,
    input  sel, gnt, gnt_valid, timeout, dout
  );

  modport slave (
    input  req, done, din,
    output sel, gnt, gnt_valid, timeout, dout
  );
endinterface

// File: rtl/mux16_rr_arbiter.sv
// mux16to1: plain 16:1 single-bit mux, inputs a..p selected by {s3,s2,s1,s0}.
// mux16_rr_arbiter: round-robin arbiter + sequencer in front of mux16to1.
//   clk, rst_n : clock, synchronous active-low reset
//   bus (slave): req[15:0], done, din[15:0] in; sel[3:0], gnt[15:0],
//                gnt_valid, timeout (all registered), dout (combinational) out
//   HOLD_MAX   : longest grant in cycles (1..255)
module mux16to1 (
  input  logic a, b, c, d, e, f, g, h, i, j, k, l, m, n, o, p,
  input  logic s3, s2, s1, s0,
  output logic y
);
  logic [15:0] in_vec;
  assign in_vec = {p, o, n, m, l, k, j, i, h, g, f, e, d, c, b, a};
  assign y      = in_vec[{s3, s2, s1, s0}];
endmodule

module mux16_rr_arbiter #(
  parameter int HOLD_MAX = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mux16_rr_arbiter_if.slave    bus
);
  localparam int HW = $clog2(HOLD_MAX) + 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_MAX - 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [3:0]    ptr_q, ptr_d;
  logic [3:0]    sel_q, sel_d;
  logic [15:0]   gnt_q, gnt_d;
  logic          gnt_valid_q, gnt_valid_d;
  logic          timeout_q, timeout_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;

  // First requester at or after start, mod 16. Bit 4 = found.
  // Scanning from the far end down lets the nearest hit overwrite the rest.
  function automatic logic [4:0] rr_search(input logic [15:0] r, input logic [3:0] start);
    logic [4:0] res;
    logic [3:0] idx;
    res = 5'd0;
    for (int k = 15; k >= 0; k--) begin
      idx = start + 4'(k);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  logic [3:0] search_start;
  logic [4:0] found;
  logic       rel_user, rel_hold, release_now;

  // In GRANT the search always starts just past the current grantee, so
  // the released channel drops to lowest priority.
  assign search_start = (state_q == GRANT) ? sel_q + 4'd1 : ptr_q;
  assign found        = rr_search(bus.req, search_start);
  assign rel_user     = bus.done | ~bus.req[sel_q];
  assign rel_hold     = (hold_cnt_q == HOLD_LAST);
  assign release_now  = rel_user | rel_hold;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    sel_d       = sel_q;
    gnt_d       = gnt_q;
    gnt_valid_d = gnt_valid_q;
    timeout_d   = 1'b0;
    hold_cnt_d  = hold_cnt_q;
    if (state_q == IDLE || release_now) begin
      if (state_q == GRANT) begin
        ptr_d     = sel_q + 4'd1;
        timeout_d = rel_hold & ~rel_user;
      end
      hold_cnt_d = '0;
      if (found[4]) begin
        state_d     = GRANT;
        sel_d       = found[3:0];
        gnt_d       = 16'd1 << found[3:0];
        gnt_valid_d = 1'b1;
      end else begin
        state_d     = IDLE;
        gnt_d       = '0;
        gnt_valid_d = 1'b0;
      end
    end else begin
      hold_cnt_d = hold_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      sel_q       <= '0;
      gnt_q       <= '0;
      gnt_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
      hold_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      sel_q       <= sel_d;
      gnt_q       <= gnt_d;
      gnt_valid_q <= gnt_valid_d;
      timeout_q   <= timeout_d;
      hold_cnt_q  <= hold_cnt_d;
    end
  end

  logic mux_y;

  mux16to1 u_mux (
    .a(bus.din[0]),  .b(bus.din[1]),  .c(bus.din[2]),  .d(bus.din[3]),
    .e(bus.din[4]),  .f(bus.din[5]),  .g(bus.din[6]),  .h(bus.din[7]),
    .i(bus.din[8]),  .j(bus.din[9]),  .k(bus.din[10]), .l(bus.din[11]),
    .m(bus.din[12]), .n(bus.din[13]), .o(bus.din[14]), .p(bus.din[15]),
    .s3(sel_q[3]), .s2(sel_q[2]), .s1(sel_q[1]), .s0(sel_q[0]),
    .y(mux_y)
  );

  assign bus.sel       = sel_q;
  assign bus.gnt       = gnt_q;
  assign bus.gnt_valid = gnt_valid_q;
  assign bus.timeout   = timeout_q;
  assign bus.dout      = gnt_valid_q & mux_y;
endmodule
